led_dimmer_multi: RTL and testbench
===================================

# led_dimmer_multi

Multi-channel PWM LED dimmer for the Arty A7 board LEDs. It supersedes the per-LED fixed-intensity dimmer instances with one block that has a shared PWM timebase and run-time programmable per-channel intensity. Intensity changes are applied glitch-free on PWM frame boundaries, with an optional linear fade. It sits between the board top level (switches, control logic) and the LED pins.

## Interface

Parameters:
- NCH, 4: number of LED channels (1..16).
- WIDTH, 12: intensity/PWM resolution in bits (2..16).
- PRESC, 1: clocks per PWM tick (≥1). Frame length is PRESC·2^WIDTH clocks.
- FADE_STEP, 1: level change per frame when fading (1..2^WIDTH−1).
- INIT_LEVEL, 0: reset value of every channel's target and level.

Ports:
- clk, input, 1: system clock. All logic is rising-edge.
- ck_rst, input, 1: asynchronous active-low reset.
- en, input, NCH: per-channel enable. 0 forces the LED low; level and target keep running.
- wr_en, input, 1: one-cycle write strobe for the target intensity.
- wr_ch, input, 4: channel index for the write.
- wr_level, input, WIDTH: new target intensity.
- led, output, NCH: PWM LED drive, registered.
- busy, output, NCH: per channel, level ≠ target.
- frame, output, 1: one-cycle pulse on each PWM frame boundary.

## Operation

- Prescaler counts 0..PRESC−1. Tick is asserted when the prescaler equals PRESC−1, then it wraps to 0. With PRESC=1, tick is asserted every cycle.
- pwm_cnt is WIDTH bits and increments on each tick, wrapping from 2^WIDTH−1 to 0.
- A boundary occurs when tick=1 and pwm_cnt=2^WIDTH−1. frame is registered and pulses high for one cycle after the boundary cycle.
- Writes:
  - wr_en=1 with wr_ch<NCH sets target[wr_ch]=wr_level on the next edge.
  - wr_ch≥NCH is ignored.
  - No handshake is used; a write is accepted every cycle.
- Level update happens only on a boundary cycle, per channel:
  - With fade compiled in: if level<target, level=min(level+FADE_STEP, target); if level>target, level=max(level−FADE_STEP, target). Saturation must not wrap; compute with a WIDTH+1-bit intermediate.
  - With fade compiled out: level=target.
- A write and a boundary in the same cycle: the boundary uses the old target. The new target takes effect at the next boundary.
- LED compare:
  - led[c] is the registered value of en[c] & ((pwm_cnt < level[c]) | (level[c] = 2^WIDTH−1)).
  - level 0 gives constant off. All-ones gives constant on. Level L otherwise gives duty L/2^WIDTH.
- busy[c] is registered (level[c] ≠ target[c]), evaluated on the post-update values.
- Reset (ck_rst=0, asynchronous):
  - Prescaler and pwm_cnt are 0.
  - target and level are INIT_LEVEL.
  - led=0, busy=0, frame=0.
  - Reset asserted mid-fade or mid-frame aborts immediately. The first frame after release starts at pwm_cnt=0.

## Timing

- Write to target: 1 cycle.
- Target to visible duty change: at the next boundary, then 1 cycle of LED register latency. Worst case is one frame plus 2 cycles.
- en change to led: 1 cycle.
- A full fade from a to b takes ceil(|b−a|/FADE_STEP) frames.
- led is glitch-free: level never changes mid-frame, so each frame has exactly one high run starting at pwm_cnt=0.

## Configuration

- LED_DIMMER_FADE_EN defined: linear fade by FADE_STEP per frame, as above. busy can stay high for multiple frames.
- LED_DIMMER_FADE_EN undefined: level=target at each boundary, and the fade arithmetic is not synthesised. busy is high only from the write until the next boundary.

## Test plan

Bench parameters: NCH=4, WIDTH=4, PRESC=2, FADE_STEP=1, INIT_LEVEL=0, giving a 32-clock frame.
- Reset hold, then release, all en=1 → led=0000, busy=0000; frame pulses every 32 cycles, first pulse 32 cycles after release.
- Fade compiled out; write ch0=5 mid-frame → busy[0]=1 until the boundary. From the next frame, led[0] is high 10 clocks and low 22 clocks per frame.
- Write ch1=15 → led[1] constant high after the boundary. Then write 0 → constant low, with no pulses.
- Fade compiled in; write ch2=4 → high-time grows 2, 4, 6, 8 clocks over 4 frames. busy[2] falls after the 4th boundary. Write ch2=15 then 0 before level reaches 15 → level reverses direction with no wrap below 0.
- Write on the boundary cycle, ch3=7 with old target 0 → ch3 unchanged this frame; the update applies one frame later. wr_ch=9 → no channel changes.
- en[0]=0 while ch0=5 → led[0]=0 one cycle later. Re-enable mid-frame → output matches pwm_cnt<5. Assert ck_rst mid-fade → led, busy and frame are 0 asynchronously, and levels equal INIT_LEVEL after release.

Source files
------------

// File: rtl/led_dimmer_multi.sv
// Multi-channel PWM LED dimmer: shared timebase, per-channel programmable intensity
// applied on frame boundaries. Define LED_DIMMER_FADE_EN to ramp levels by FADE_STEP per frame.
module led_dimmer_multi #(
  parameter int NCH        = 4,
  parameter int WIDTH      = 12,
  parameter int PRESC      = 1,
  parameter int FADE_STEP  = 1,
  parameter int INIT_LEVEL = 0
) (
  input  logic             clk,
  input  logic             ck_rst,
  input  logic [NCH-1:0]   en,
  input  logic             wr_en,
  input  logic [3:0]       wr_ch,
  input  logic [WIDTH-1:0] wr_level,
  output logic [NCH-1:0]   led,
  output logic [NCH-1:0]   busy,
  output logic             frame
);

  localparam int               PW         = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESC - 1);
  localparam logic [WIDTH-1:0] LEVEL_INIT = WIDTH'(INIT_LEVEL);

  logic [PW-1:0]    presc_cnt;
  logic [WIDTH-1:0] pwm_cnt;
  logic             tick;
  logic             boundary;

  logic [WIDTH-1:0] target     [NCH];
  logic [WIDTH-1:0] level      [NCH];
  logic [WIDTH-1:0] target_nxt [NCH];
  logic [WIDTH-1:0] level_nxt  [NCH];

  assign tick     = (presc_cnt == PRESC_LAST);
  assign boundary = tick && (pwm_cnt == '1);

`ifdef LED_DIMMER_FADE_EN
  localparam logic [WIDTH:0] STEP = (WIDTH + 1)'(FADE_STEP);

  // The gap is measured one bit wider so that a step never overshoots or wraps past the target.
  function automatic logic [WIDTH-1:0] fade(input logic [WIDTH-1:0] cur,
                                            input logic [WIDTH-1:0] tgt);
    logic [WIDTH:0] gap;
    gap  = '0;
    fade = cur;
    if (cur < tgt) begin
      gap  = {1'b0, tgt} - {1'b0, cur};
      fade = (gap <= STEP) ? tgt : cur + STEP[WIDTH-1:0];
    end else if (cur > tgt) begin
      gap  = {1'b0, cur} - {1'b0, tgt};
      fade = (gap <= STEP) ? tgt : cur - STEP[WIDTH-1:0];
    end
  endfunction
`endif

  // The boundary reads the registered target, so a write landing on the boundary cycle
  // only takes effect one frame later.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      // NOTE: every comb output gets a default first so no path can infer a latch.
      target_nxt[c] = target[c];
      level_nxt[c]  = level[c];
      if (wr_en && (wr_ch == 4'(c))) target_nxt[c] = wr_level;
      if (boundary) begin
`ifdef LED_DIMMER_FADE_EN
        level_nxt[c] = fade(level[c], target[c]);
`else
        level_nxt[c] = target[c];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge ck_rst) begin
    if (!ck_rst) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
      frame     <= 1'b0;
      led       <= '0;
      busy      <= '0;
      // NOTE: target/level are state, not storage; each entry must come out of reset at INIT_LEVEL.
      for (int c = 0; c < NCH; c++) begin
        target[c] <= LEVEL_INIT;
        level[c]  <= LEVEL_INIT;
      end
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the pre-edge state.
      presc_cnt <= tick ? '0 : presc_cnt + PW'(1);
      if (tick) pwm_cnt <= pwm_cnt + WIDTH'(1);
      frame <= boundary;
      for (int c = 0; c < NCH; c++) begin
        target[c] <= target_nxt[c];
        level[c]  <= level_nxt[c];
        led[c]    <= en[c] & ((pwm_cnt < level[c]) | (level[c] == '1));
        busy[c]   <= (level_nxt[c] != target_nxt[c]);
      end
    end
  end

endmodule

// File: tb/tb_led_dimmer_multi.sv
// Self-checking bench for led_dimmer_multi: per-frame LED high-time scoreboard,
// table-driven writes, and hand sequences for boundary writes, enable and reset.
`timescale 1ns/1ps
module tb_led_dimmer_multi;

  localparam int NCH        = 4;
  localparam int WIDTH      = 4;
  localparam int PRESC      = 2;
  localparam int FADE_STEP  = 1;
  localparam int INIT_LEVEL = 0;
  localparam int FRAME      = PRESC * (1 << WIDTH);
  localparam int LMAX       = (1 << WIDTH) - 1;
`ifdef LED_DIMMER_FADE_EN
  localparam bit FADE = 1'b1;
`else
  localparam bit FADE = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             ck_rst;
  logic [NCH-1:0]   en;
  logic             wr_en;
  logic [3:0]       wr_ch;
  logic [WIDTH-1:0] wr_level;
  logic [NCH-1:0]   led;
  logic [NCH-1:0]   busy;
  logic             frame;

  led_dimmer_multi #(
    .NCH(NCH), .WIDTH(WIDTH), .PRESC(PRESC), .FADE_STEP(FADE_STEP), .INIT_LEVEL(INIT_LEVEL)
  ) dut (
    .clk(clk), .ck_rst(ck_rst), .en(en), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_level(wr_level), .led(led), .busy(busy), .frame(frame)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct { int high[NCH]; } frame_exp_t;
  typedef struct {
    logic [3:0]     ch;
    int             lvl;
    logic [NCH-1:0] busy;
    int             high[NCH];
  } vec_t;

  frame_exp_t     sb[$];
  vec_t           vecs[5];
  int             exp_lvl[NCH];
  int             exp_tgt[NCH];
  int             last_cnt[NCH];
  logic [NCH-1:0] last_busy_wr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int high_of(input int l);
    return (l == LMAX) ? FRAME : PRESC * l;
  endfunction

  function automatic logic [NCH-1:0] model_busy();
    logic [NCH-1:0] b;
    for (int c = 0; c < NCH; c++) b[c] = (exp_lvl[c] != exp_tgt[c]);
    return b;
  endfunction

  function automatic bit settled();
    for (int c = 0; c < NCH; c++) if (exp_lvl[c] != exp_tgt[c]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      exp_lvl[c] = INIT_LEVEL;
      exp_tgt[c] = INIT_LEVEL;
    end
    sb.delete();
  endtask

  task automatic apply_write(input logic [3:0] ch, input int lvl);
    if (int'(ch) < NCH) exp_tgt[ch] = lvl;
  endtask

  // Frame boundary in the model: levels move, and the next frame's high times are queued.
  task automatic model_boundary();
    frame_exp_t e;
    for (int c = 0; c < NCH; c++) begin
      if (FADE) begin
        if (exp_lvl[c] < exp_tgt[c])
          exp_lvl[c] = (exp_tgt[c] - exp_lvl[c] > FADE_STEP) ? exp_lvl[c] + FADE_STEP : exp_tgt[c];
        else if (exp_lvl[c] > exp_tgt[c])
          exp_lvl[c] = (exp_lvl[c] - exp_tgt[c] > FADE_STEP) ? exp_lvl[c] - FADE_STEP : exp_tgt[c];
      end else begin
        exp_lvl[c] = exp_tgt[c];
      end
      e.high[c] = high_of(exp_lvl[c]);
    end
    sb.push_back(e);
  endtask

  // Starts and ends on the negedge of a frame-pulse cycle; measures one whole frame of led.
  task automatic step(input bit do_wr, input logic [3:0] ch, input int lvl, input int widx);
    frame_exp_t e;
    bit pend;
    pend = 1'b0;
    for (int c = 0; c < NCH; c++) last_cnt[c] = 0;
    for (int i = 1; i <= FRAME; i++) begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++) last_cnt[c] += int'(led[c]);
      if (i == FRAME) check("frame_period", 32'(frame), 32'd1);
      if (do_wr && i == widx + 1) begin
        wr_en = 1'b0;
        if (i < FRAME) begin
          apply_write(ch, lvl);
          last_busy_wr = busy;
          check("busy_after_write", 32'(busy), 32'(model_busy()));
        end else begin
          pend = 1'b1;
        end
      end
      if (do_wr && i == widx) begin
        wr_en    = 1'b1;
        wr_ch    = ch;
        wr_level = WIDTH'(lvl);
      end
    end
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      for (int c = 0; c < NCH; c++) check($sformatf("high_ch%0d", c), 32'(last_cnt[c]), 32'(e.high[c]));
    end
    model_boundary();
    if (pend) apply_write(ch, lvl);
    check("busy_at_frame", 32'(busy), 32'(model_busy()));
  endtask

  task automatic settle();
    for (int k = 0; k < 40 && !settled(); k++) step(1'b0, 4'd0, 0, 0);
    check("settle_bound", 32'(settled()), 32'd1);
  endtask

  task automatic wait_first_frame(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame && n < 2 * FRAME);
    check(name, 32'(n), 32'(FRAME));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_led"}, 32'(led), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_frame"}, 32'(frame), 32'd0);
  endtask

  initial begin
    vecs[0] = '{4'd0,  5,  4'b0001, '{10, 0,  0, 0}};
    vecs[1] = '{4'd1,  15, 4'b0010, '{10, 32, 0, 0}};
    vecs[2] = '{4'd1,  0,  4'b0010, '{10, 0,  0, 0}};
    vecs[3] = '{4'd9,  7,  4'b0000, '{10, 0,  0, 0}};
    vecs[4] = '{4'd2,  4,  4'b0100, '{10, 0,  8, 0}};

    ck_rst   = 1'b0;
    en       = '1;
    wr_en    = 1'b0;
    wr_ch    = '0;
    wr_level = '0;
    model_reset();

    repeat (3) @(negedge clk);
    check_outputs_zero("reset_hold");
    ck_rst = 1'b1;
    wait_first_frame("first_frame_latency");
    model_boundary();
    check("busy_idle", 32'(busy), 32'd0);

    for (int v = 0; v < 5; v++) begin
      step(1'b1, vecs[v].ch, vecs[v].lvl, 4);
      check($sformatf("vec%0d_busy_wr", v), 32'(last_busy_wr), 32'(vecs[v].busy));
      settle();
      step(1'b0, 4'd0, 0, 0);
      for (int c = 0; c < NCH; c++)
        check($sformatf("vec%0d_final_ch%0d", v, c), 32'(last_cnt[c]), 32'(vecs[v].high[c]));
    end

    // Direction reversal on ch2: climb toward 15, then head back down to 0.
    step(1'b1, 4'd2, 15, 4);
    step(1'b0, 4'd0, 0, 0);
    step(1'b0, 4'd0, 0, 0);
    step(1'b1, 4'd2, 0, 4);
    settle();
    step(1'b0, 4'd0, 0, 0);
    check("reversal_floor_ch2", 32'(last_cnt[2]), 32'd0);

    // Write on the boundary cycle: ch3 keeps its old level for one more frame.
    step(1'b1, 4'd3, 7, FRAME - 1);
    step(1'b0, 4'd0, 0, 0);
    check("boundary_write_same", 32'(last_cnt[3]), 32'd0);
    step(1'b0, 4'd0, 0, 0);
    check("boundary_write_next", 32'(last_cnt[3]), FADE ? 32'd2 : 32'd14);
    settle();
    step(1'b0, 4'd0, 0, 0);
    check("boundary_write_final", 32'(last_cnt[3]), 32'd14);

    // Enable gating on ch0 (level 5) within one frame.
    begin
      frame_exp_t e;
      for (int c = 0; c < NCH; c++) last_cnt[c] = 0;
      for (int i = 1; i <= FRAME; i++) begin
        @(negedge clk);
        for (int c = 0; c < NCH; c++) last_cnt[c] += int'(led[c]);
        if (i == 3) check("en_off_led0", 32'(led[0]), 32'd0);
        if (i >= 6) check($sformatf("en_on_led0_i%0d", i), 32'(led[0]), 32'(((i - 1) / PRESC) < 5));
        if (i == FRAME) check("frame_period", 32'(frame), 32'd1);
        if (i == 2) en[0] = 1'b0;
        if (i == 5) en[0] = 1'b1;
      end
      e = sb.pop_front();
      for (int c = 1; c < NCH; c++) check($sformatf("en_frame_ch%0d", c), 32'(last_cnt[c]), 32'(e.high[c]));
      model_boundary();
      check("busy_at_frame", 32'(busy), 32'(model_busy()));
    end

    // Asynchronous reset in the middle of a ramp.
    step(1'b1, 4'd2, 15, 4);
    step(1'b0, 4'd0, 0, 0);
    @(negedge clk);
    check("pre_reset_led2", 32'(led[2]), 32'd1);
    #2 ck_rst = 1'b0;
    #1 check_outputs_zero("async_reset");
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_held");
    ck_rst = 1'b1;
    model_reset();
    wait_first_frame("first_frame_after_reset");
    model_boundary();
    check("busy_after_reset", 32'(busy), 32'd0);
    step(1'b0, 4'd0, 0, 0);
    check("post_reset_level_ch2", 32'(last_cnt[2]), 32'(high_of(INIT_LEVEL)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "watchdog");
  end

endmodule
